// File: rtl/board_io_conditioner.sv
// board_io_conditioner
//   Conditions raw board pins (switches, buttons) for the gpioA read vector.
//   Each channel is synchronised, debounced, edge-detected and captured into
//   a sticky event flag; the event flags are ORed into a single interrupt.
//   All channels are independent and share nothing but the clock and reset.

module board_io_conditioner #(
    parameter int CHANNELS        = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RESET_LEVEL     = 0
) (
    input  logic                clk100,
    input  logic                cpu_reset,
    input  logic [CHANNELS-1:0] io_pins_in,
    input  logic [CHANNELS-1:0] io_rise_en,
    input  logic [CHANNELS-1:0] io_fall_en,
    input  logic [CHANNELS-1:0] io_event_clear,
    output logic [CHANNELS-1:0] io_level,
    output logic [CHANNELS-1:0] io_event,
    output logic                io_irq
);

    // Counter only has to reach DEBOUNCE_CYCLES-1, so this width never wraps.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Reset value shared by every sync flop and every debounced level bit.
    localparam logic [CHANNELS-1:0] RST_VEC =
        (RESET_LEVEL != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

    // Count value on which a differing synchronised level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0]                  sync_s;

    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q;
    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_d;

    logic [CHANNELS-1:0]                  level_q;
    logic [CHANNELS-1:0]                  level_d;
    logic [CHANNELS-1:0]                  level_prev_q;

    logic [CHANNELS-1:0]                  rise;
    logic [CHANNELS-1:0]                  fall;
    logic [CHANNELS-1:0]                  event_set;
    logic [CHANNELS-1:0]                  event_q;
    logic [CHANNELS-1:0]                  event_d;

    // ------------------------------------------------------------------
    // Synchroniser: a plain shift chain, nothing between the stages so the
    // metastability settling time of each stage is a full clock period.
    // ------------------------------------------------------------------

    // Shift raw pins through SYNC_STAGES flops.
    always_ff @(posedge clk100 or negedge cpu_reset) begin
        if (!cpu_reset) begin
            sync_q <= {SYNC_STAGES{RST_VEC}};
        end else begin
            // NOTE: non-blocking assignments let every stage sample the old
            // value of the previous stage, which is what makes this a chain.
            sync_q[0] <= io_pins_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce: a channel's counter runs only while the synchronised level
    // disagrees with the accepted level; any agreement restarts it, so only
    // an uninterrupted run of DEBOUNCE_CYCLES disagreeing samples is taken.
    // ------------------------------------------------------------------

    // Per-channel debounce next-state.
    always_comb begin
        // NOTE: defaults first so every path assigns cnt_d/level_d and no
        // latch is inferred for channels or branches that do not update.
        cnt_d   = cnt_q;
        level_d = level_q;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (sync_s[ch] == level_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                level_d[ch] = sync_s[ch];
                cnt_d[ch]   = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
    end

    // Debounce counters, accepted level and its one-cycle-old copy.
    always_ff @(posedge clk100 or negedge cpu_reset) begin
        if (!cpu_reset) begin
            // NOTE: the counter bank is reset like any other register; a
            // stale count surviving reset would shorten the first debounce.
            cnt_q        <= '0;
            level_q      <= RST_VEC;
            level_prev_q <= RST_VEC;
        end else begin
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    // ------------------------------------------------------------------
    // Edge capture. level_prev_q resets to the same value as level_q, so
    // reset release can never look like an edge.
    // ------------------------------------------------------------------

    // Edge pulses and sticky event next-state; a set beats a same-cycle clear.
    always_comb begin
        rise      = level_q & ~level_prev_q;
        fall      = ~level_q & level_prev_q;
        event_set = (rise & io_rise_en) | (fall & io_fall_en);
        event_d   = event_set | (event_q & ~io_event_clear);
    end

    // Sticky event flags.
    always_ff @(posedge clk100 or negedge cpu_reset) begin
        if (!cpu_reset) begin
            event_q <= '0;
        end else begin
            event_q <= event_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all driven straight from registers; the irq OR has no
    // combinational input path, so it cannot glitch on pin activity.
    // ------------------------------------------------------------------
    assign io_level = level_q;
    assign io_event = event_q;
    assign io_irq   = |event_q;

endmodule

// File: tb/tb_board_io_conditioner.sv
// tb_board_io_conditioner
//   Table-driven vectors, hand-written multi-cycle sequences and a randomized
//   run compared against a window-based reference model.

module tb_board_io_conditioner;

    localparam int CH   = 8;
    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic          clk100         = 1'b0;
    logic          cpu_reset      = 1'b0;
    logic [CH-1:0] io_pins_in     = '0;
    logic [CH-1:0] io_rise_en     = '0;
    logic [CH-1:0] io_fall_en     = '0;
    logic [CH-1:0] io_event_clear = '0;
    logic [CH-1:0] io_level;
    logic [CH-1:0] io_event;
    logic          io_irq;

    int checks = 0;
    int errors = 0;

    board_io_conditioner #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .RESET_LEVEL    (0)
    ) dut (
        .clk100        (clk100),
        .cpu_reset     (cpu_reset),
        .io_pins_in    (io_pins_in),
        .io_rise_en    (io_rise_en),
        .io_fall_en    (io_fall_en),
        .io_event_clear(io_event_clear),
        .io_level      (io_level),
        .io_event      (io_event),
        .io_irq        (io_irq)
    );

    always #5 clk100 = ~clk100;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk100);
    endtask

    // ------------------------------------------------------------------
    // Reference model. A pin value reaches the debouncer SYNC edges after it
    // is sampled; the accepted level flips once the last DEB values seen all
    // disagree with it. Events follow the accepted level's one-cycle history.
    // ------------------------------------------------------------------
    logic [CH-1:0] m_pipe[$];
    logic [CH-1:0] m_win[$];
    logic [CH-1:0] m_level = '0;
    logic [CH-1:0] m_prev  = '0;
    logic [CH-1:0] m_event = '0;
    logic [CH-1:0] m_s;
    logic [CH-1:0] m_set;
    logic          m_all;

    always @(posedge clk100 or negedge cpu_reset) begin
        if (!cpu_reset) begin
            m_pipe.delete();
            for (int i = 0; i < SYNC; i++) m_pipe.push_back('0);
            m_win.delete();
            m_level = '0;
            m_prev  = '0;
            m_event = '0;
        end else begin
            m_s = m_pipe.pop_front();
            m_pipe.push_back(io_pins_in);
            m_win.push_back(m_s);
            if (m_win.size() > DEB) void'(m_win.pop_front());
            m_set   = (m_level & ~m_prev & io_rise_en) | (~m_level & m_prev & io_fall_en);
            m_event = m_set | (m_event & ~io_event_clear);
            m_prev  = m_level;
            if (m_win.size() == DEB) begin
                for (int ch = 0; ch < CH; ch++) begin
                    m_all = 1'b1;
                    foreach (m_win[k]) if (m_win[k][ch] == m_level[ch]) m_all = 1'b0;
                    if (m_all) m_level[ch] = ~m_level[ch];
                end
            end
        end
    end

    task automatic cmp_model(input string tag);
        check({tag, "_level"}, io_level, m_level);
        check({tag, "_event"}, io_event, m_event);
        check({tag, "_irq"}, {7'b0, io_irq}, {7'b0, |m_event});
    endtask

    // ------------------------------------------------------------------
    // Vector table: inputs held for 'cycles' edges, then outputs compared.
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] pins;
        logic [7:0] rise_en;
        logic [7:0] fall_en;
        logic [7:0] clr;
        int         cycles;
        logic [7:0] exp_level;
        logic [7:0] exp_event;
    } vec_t;

    localparam int NVEC = 10;
    vec_t tbl [NVEC];
    logic [7:0] flip;

    initial begin
        // Starts with io_level=FF, io_event=00 after the reset sequence.
        tbl[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 6, 8'h00, 8'h00}; // fall, not enabled
        tbl[1] = '{8'h00, 8'h01, 8'h00, 8'h00, 2, 8'h00, 8'h00}; // idle
        tbl[2] = '{8'h01, 8'h01, 8'h00, 8'h00, 6, 8'h01, 8'h00}; // ch0 level rises
        tbl[3] = '{8'h01, 8'h01, 8'h00, 8'h00, 1, 8'h01, 8'h01}; // event a cycle later
        tbl[4] = '{8'h01, 8'h01, 8'h00, 8'h01, 1, 8'h01, 8'h00}; // W1C
        tbl[5] = '{8'h03, 8'h00, 8'h02, 8'h00, 7, 8'h03, 8'h00}; // ch1 rise ignored
        tbl[6] = '{8'h01, 8'h00, 8'h02, 8'h00, 6, 8'h01, 8'h00}; // ch1 level falls
        tbl[7] = '{8'h01, 8'h00, 8'h02, 8'h00, 1, 8'h01, 8'h02}; // fall captured
        tbl[8] = '{8'h01, 8'h00, 8'h00, 8'h02, 1, 8'h01, 8'h00}; // W1C
        tbl[9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8, 8'h00, 8'h00}; // ch0 fall, not enabled

        // Reset held with all pins high: nothing propagates.
        io_pins_in = 8'hFF;
        repeat (3) begin
            tick();
            check("rst_level", io_level, 8'h00);
            check("rst_event", io_event, 8'h00);
            check("rst_irq", {7'b0, io_irq}, 8'h00);
        end
        cpu_reset = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("pwrup_level", io_level, (i == 6) ? 8'hFF : 8'h00);
            check("pwrup_event", io_event, 8'h00);
        end

        for (int i = 0; i < NVEC; i++) begin
            io_pins_in     = tbl[i].pins;
            io_rise_en     = tbl[i].rise_en;
            io_fall_en     = tbl[i].fall_en;
            io_event_clear = tbl[i].clr;
            repeat (tbl[i].cycles) tick();
            check($sformatf("vec%0d_level", i), io_level, tbl[i].exp_level);
            check($sformatf("vec%0d_event", i), io_event, tbl[i].exp_event);
            check($sformatf("vec%0d_irq", i), {7'b0, io_irq}, {7'b0, |tbl[i].exp_event});
        end
        io_event_clear = '0;

        // Bounce: 3-cycle high pulse, 2 low, then steady high.
        io_pins_in = 8'h01;
        repeat (3) begin tick(); check("bounce_hi", io_level, 8'h00); end
        io_pins_in = 8'h00;
        repeat (2) begin tick(); check("bounce_lo", io_level, 8'h00); end
        io_pins_in = 8'h01;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("bounce_steady", io_level, (i == 6) ? 8'h01 : 8'h00);
        end

        // Set/clear collision on ch2.
        io_rise_en = 8'h04;
        io_pins_in = 8'h05;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("coll_level", io_level, (i == 6) ? 8'h05 : 8'h01);
        end
        io_event_clear = 8'h04;
        tick();
        check("coll_set_wins", io_event, 8'h04);
        check("coll_irq", {7'b0, io_irq}, 8'h01);
        tick();
        check("coll_lone_clear", io_event, 8'h00);
        check("coll_irq_clr", {7'b0, io_irq}, 8'h00);
        io_event_clear = '0;

        // Async reset in the middle of a pending ch3 change.
        io_rise_en = 8'h02;
        io_pins_in = 8'h07;
        repeat (7) tick();
        check("pre_rst_level", io_level, 8'h07);
        check("pre_rst_event", io_event, 8'h02);
        io_rise_en = 8'h00;
        io_pins_in = 8'h0F;
        repeat (4) tick();
        check("pending_level", io_level, 8'h07);
        #2 cpu_reset = 1'b0;
        #1;
        check("async_level", io_level, 8'h00);
        check("async_event", io_event, 8'h00);
        check("async_irq", {7'b0, io_irq}, 8'h00);
        tick();
        check("held_level", io_level, 8'h00);
        cpu_reset = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("rerun_level", io_level, (i == 6) ? 8'h0F : 8'h00);
            check("rerun_event", io_event, 8'h00);
        end

        // Randomized run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            cmp_model("rnd");
            if (!cpu_reset) cpu_reset = 1'b1;
            for (int b = 0; b < CH; b++) flip[b] = ($urandom_range(0, 5) == 0);
            io_pins_in     = io_pins_in ^ flip;
            io_rise_en     = 8'($urandom);
            io_fall_en     = 8'($urandom);
            io_event_clear = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 499) == 0) begin
                #2 cpu_reset = 1'b0;
                #1 cmp_model("rnd_rst");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
